// File: rtl/lsu_agu_pipe_if.sv
`default_nettype none
// ============================================================================
// Module      : lsu_agu_pipe_if
// Description : Request and beat handshake bundle for the load/store AGU.
// Revision    : 1.0 - initial release
// ============================================================================
interface lsu_agu_pipe_if #(
    parameter int SRC_W     = 32,
    parameter int ADDR_W    = 12,
    parameter int SV_W      = 2,
    parameter int MAX_BURST = 8
);
    localparam int c_bl_w = $clog2(MAX_BURST) + 1;

    logic              in_valid;
    logic              in_ready;
    logic [5:0]        opcode;
    logic [7:0]        sub_opcode_8bit;
    logic [SRC_W-1:0]  src1;
    logic [SRC_W-1:0]  src2;
    logic [SV_W-1:0]   sv;
    logic [c_bl_w-1:0] burst_len;
    logic              out_valid;
    logic              out_ready;
    logic [ADDR_W-1:0] addr;
    logic              is_store;
    logic              last;
    logic              misalign;

    modport master (
        output in_valid, opcode, sub_opcode_8bit, src1, src2, sv, burst_len, out_ready,
        input  in_ready, out_valid, addr, is_store, last, misalign
    );

    modport slave (
        input  in_valid, opcode, sub_opcode_8bit, src1, src2, sv, burst_len, out_ready,
        output in_ready, out_valid, addr, is_store, last, misalign
    );
endinterface
`default_nettype wire

// File: rtl/lsu_agu_pipe.sv
`default_nettype none
// ============================================================================
// Module      : lsu_agu_pipe
// Description : Registered load/store address generator with LMW burst
//               sequencer. Define LSU_AGU_MISALIGN_CHK_EN for misalign flag.
// Revision    : 1.0 - initial release
// ============================================================================
module lsu_agu_pipe #(
    parameter int SRC_W     = 32,
    parameter int ADDR_W    = 12,
    parameter int SV_W      = 2,
    parameter int MAX_BURST = 8
) (
    input  wire logic      clk,
    input  wire logic      reset,
    lsu_agu_pipe_if.slave  bus
);
    localparam int         c_cnt_w   = $clog2(MAX_BURST) + 1;
    localparam int         c_ext_w   = (SRC_W > ADDR_W) ? SRC_W : ADDR_W;
    localparam logic [5:0] c_op_lwi  = 6'b000010;
    localparam logic [5:0] c_op_swi  = 6'b001010;
    localparam logic [5:0] c_op_ls   = 6'b011100;
    localparam logic [7:0] c_sub_lw  = 8'h02;
    localparam logic [7:0] c_sub_sw  = 8'h0A;
    localparam logic [7:0] c_sub_lmw = 8'h22;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } state_t;

    state_t              r_state, w_state_nx;
    logic [c_cnt_w-1:0]  r_cnt, w_cnt_nx;
    logic [c_cnt_w-1:0]  r_len, w_len_nx;
    logic [ADDR_W-1:0]   r_base, w_base_nx;
    logic                r_out_valid, w_valid_nx;
    logic [ADDR_W-1:0]   r_addr, w_addr_nx;
    logic                r_is_store, w_store_nx;
    logic                r_last, w_last_nx;

    logic                w_in_ready, w_accept, w_out_fire;
    logic                w_is_lwi, w_is_swi, w_is_lw, w_is_sw, w_is_lmw;
    logic [ADDR_W-1:0]   w_base, w_shl_2, w_shr_2, w_shl_sv, w_shr_sv;
    logic [ADDR_W-1:0]   w_req_addr, w_beat_addr;
    logic [c_cnt_w-1:0]  w_len;

    assign w_out_fire = r_out_valid && bus.out_ready;
    assign w_in_ready = (r_state == ST_IDLE) && (!r_out_valid || bus.out_ready);
    assign w_accept   = bus.in_valid && w_in_ready;

    assign w_is_lwi = (bus.opcode == c_op_lwi);
    assign w_is_swi = (bus.opcode == c_op_swi);
    assign w_is_lw  = (bus.opcode == c_op_ls) && (bus.sub_opcode_8bit == c_sub_lw);
    assign w_is_sw  = (bus.opcode == c_op_ls) && (bus.sub_opcode_8bit == c_sub_sw);
    assign w_is_lmw = (bus.opcode == c_op_ls) && (bus.sub_opcode_8bit == c_sub_lmw);

    // Index is widened before shifting so left shifts lose nothing below bit ADDR_W.
    assign w_base   = ADDR_W'(bus.src1);
    assign w_shl_2  = ADDR_W'(c_ext_w'(bus.src2) << 2);
    assign w_shr_2  = ADDR_W'(c_ext_w'(bus.src2) >> 2);
    assign w_shl_sv = ADDR_W'(c_ext_w'(bus.src2) << bus.sv);
    assign w_shr_sv = ADDR_W'(c_ext_w'(bus.src2) >> bus.sv);

    always_comb begin
        w_req_addr = w_base;
        if (w_is_lwi)     w_req_addr = w_base + w_shl_2;
        else if (w_is_swi) w_req_addr = w_base + w_shr_2;
        else if (w_is_lw)  w_req_addr = w_base + w_shl_sv;
        else if (w_is_sw)  w_req_addr = w_base + w_shr_sv;
    end

    always_comb begin
        if (bus.burst_len == '0)
            w_len = c_cnt_w'(1);
        else if (bus.burst_len > c_cnt_w'(MAX_BURST))
            w_len = c_cnt_w'(MAX_BURST);
        else
            w_len = bus.burst_len;
    end

    assign w_beat_addr = r_base + ADDR_W'({r_cnt, 2'b00});

    always_comb begin
        w_state_nx = r_state;
        w_cnt_nx   = r_cnt;
        w_len_nx   = r_len;
        w_base_nx  = r_base;
        w_valid_nx = r_out_valid && !bus.out_ready;
        w_addr_nx  = r_addr;
        w_store_nx = r_is_store;
        w_last_nx  = r_last;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    if (w_is_lmw) begin
                        w_valid_nx = 1'b1;
                        w_addr_nx  = w_base;
                        w_store_nx = 1'b0;
                        w_last_nx  = (w_len == c_cnt_w'(1));
                        if (w_len != c_cnt_w'(1)) begin
                            w_state_nx = ST_BURST;
                            w_cnt_nx   = c_cnt_w'(1);
                            w_len_nx   = w_len;
                            w_base_nx  = w_base;
                        end
                    end else if (w_is_lwi || w_is_swi || w_is_lw || w_is_sw) begin
                        w_valid_nx = 1'b1;
                        w_addr_nx  = w_req_addr;
                        w_store_nx = w_is_swi || w_is_sw;
                        w_last_nx  = 1'b1;
                    end
                end
            end
            ST_BURST: begin
                if (w_out_fire) begin
                    if (r_last) begin
                        w_state_nx = ST_IDLE;
                        w_cnt_nx   = '0;
                    end else begin
                        w_valid_nx = 1'b1;
                        w_addr_nx  = w_beat_addr;
                        w_store_nx = 1'b0;
                        w_last_nx  = (r_cnt == r_len - c_cnt_w'(1));
                        w_cnt_nx   = r_cnt + c_cnt_w'(1);
                    end
                end
            end
            default: w_state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_len       <= '0;
            r_base      <= '0;
            r_out_valid <= 1'b0;
            r_addr      <= '0;
            r_is_store  <= 1'b0;
            r_last      <= 1'b0;
        end else begin
            r_state     <= w_state_nx;
            r_cnt       <= w_cnt_nx;
            r_len       <= w_len_nx;
            r_base      <= w_base_nx;
            r_out_valid <= w_valid_nx;
            r_addr      <= w_addr_nx;
            r_is_store  <= w_store_nx;
            r_last      <= w_last_nx;
        end
    end

`ifdef LSU_AGU_MISALIGN_CHK_EN
    logic r_misalign;
    always_ff @(posedge clk) begin
        if (reset) r_misalign <= 1'b0;
        else       r_misalign <= |w_addr_nx[1:0];
    end
    assign bus.misalign = r_misalign;
`else
    assign bus.misalign = 1'b0;
`endif

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.addr      = r_addr;
    assign bus.is_store  = r_is_store;
    assign bus.last      = r_last;
endmodule
`default_nettype wire

// File: tb/tb_lsu_agu_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_lsu_agu_pipe
// Description : Directed plus random bench for lsu_agu_pipe against a
//               beat-list reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lsu_agu_pipe;
    localparam int         SRC_W     = 32;
    localparam int         ADDR_W    = 12;
    localparam int         SV_W      = 2;
    localparam int         MAX_BURST = 8;
    localparam logic [5:0] c_op_lwi  = 6'b000010;
    localparam logic [5:0] c_op_swi  = 6'b001010;
    localparam logic [5:0] c_op_ls   = 6'b011100;
    localparam logic [7:0] c_sub_lw  = 8'h02;
    localparam logic [7:0] c_sub_sw  = 8'h0A;
    localparam logic [7:0] c_sub_lmw = 8'h22;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic              st;
        logic              last;
    } beat_t;

    logic  clk = 1'b0;
    logic  reset;
    int    checks   = 0;
    int    failures = 0;
    beat_t exp_q[$];

    always #5 clk = ~clk;

    lsu_agu_pipe_if #(.SRC_W(SRC_W), .ADDR_W(ADDR_W), .SV_W(SV_W), .MAX_BURST(MAX_BURST)) bus ();

    lsu_agu_pipe #(.SRC_W(SRC_W), .ADDR_W(ADDR_W), .SV_W(SV_W), .MAX_BURST(MAX_BURST)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic logic exp_mis(input logic [ADDR_W-1:0] a);
`ifdef LSU_AGU_MISALIGN_CHK_EN
        return |a[1:0];
`else
        return 1'b0;
`endif
    endfunction

    // Expected beats of one request, straight from the address formulas.
    task automatic model(input logic [5:0] op, input logic [7:0] sub, input logic [31:0] s1,
                         input logic [31:0] s2, input logic [1:0] s, input logic [3:0] bl);
        longint m;
        longint a;
        int     n;
        m = longint'(1) << ADDR_W;
        exp_q.delete();
        if (op == c_op_lwi) begin
            a = (longint'(s1) + (longint'(s2) << 2)) % m;
            exp_q.push_back('{addr: ADDR_W'(a), st: 1'b0, last: 1'b1});
        end else if (op == c_op_swi) begin
            a = (longint'(s1) + longint'(s2 >> 2)) % m;
            exp_q.push_back('{addr: ADDR_W'(a), st: 1'b1, last: 1'b1});
        end else if (op == c_op_ls && sub == c_sub_lw) begin
            a = (longint'(s1) + (longint'(s2) << s)) % m;
            exp_q.push_back('{addr: ADDR_W'(a), st: 1'b0, last: 1'b1});
        end else if (op == c_op_ls && sub == c_sub_sw) begin
            a = (longint'(s1) + longint'(s2 >> s)) % m;
            exp_q.push_back('{addr: ADDR_W'(a), st: 1'b1, last: 1'b1});
        end else if (op == c_op_ls && sub == c_sub_lmw) begin
            n = (bl == 0) ? 1 : ((int'(bl) > MAX_BURST) ? MAX_BURST : int'(bl));
            for (int k = 0; k < n; k++) begin
                a = (longint'(s1) + 4 * k) % m;
                exp_q.push_back('{addr: ADDR_W'(a), st: 1'b0, last: (k == n - 1)});
            end
        end
    endtask

    task automatic drive(input logic [5:0] op, input logic [7:0] sub, input logic [31:0] s1,
                         input logic [31:0] s2, input logic [1:0] s, input logic [3:0] bl);
        bus.opcode          = op;
        bus.sub_opcode_8bit = sub;
        bus.src1            = s1;
        bus.src2            = s2;
        bus.sv              = s;
        bus.burst_len       = bl;
    endtask

    task automatic do_req(input logic [5:0] op, input logic [7:0] sub, input logic [31:0] s1,
                          input logic [31:0] s2, input logic [1:0] s, input logic [3:0] bl,
                          input bit use_pat, input logic [7:0] pat, input int pct,
                          input string tag);
        int    n;
        int    nb;
        beat_t e;
        logic  r;
        model(op, sub, s1, s2, s, bl);
        nb = exp_q.size();
        n  = 0;
        while (!bus.in_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        chk({tag, "/in_ready_idle"}, 32'(bus.in_ready), 32'd1);
        drive(op, sub, s1, s2, s, bl);
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        n = 0;
        while (exp_q.size() > 0 && n < 200) begin
            e = exp_q[0];
            r = use_pat ? ((n < 8) ? pat[n] : 1'b1) : 1'(int'($urandom_range(0, 99)) < pct);
            bus.out_ready = r;
            #1;
            chk({tag, "/out_valid"}, 32'(bus.out_valid), 32'd1);
            chk({tag, "/addr"},      32'(bus.addr),      32'(e.addr));
            chk({tag, "/is_store"},  32'(bus.is_store),  32'(e.st));
            chk({tag, "/last"},      32'(bus.last),      32'(e.last));
            chk({tag, "/misalign"},  32'(bus.misalign),  32'(exp_mis(e.addr)));
            chk({tag, "/in_ready"},  32'(bus.in_ready),  32'((nb == 1) ? r : 1'b0));
            if (r) void'(exp_q.pop_front());
            @(posedge clk); #1;
            n++;
        end
        chk({tag, "/beats_done"}, 32'(exp_q.size()), 32'd0);
        chk({tag, "/drained_valid"}, 32'(bus.out_valid), 32'd0);
        chk({tag, "/drained_ready"}, 32'(bus.in_ready),  32'd1);
    endtask

    initial begin
        logic [5:0]  op;
        logic [7:0]  sub;
        beat_t       e;
        int          sel;

        reset         = 1'b1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        drive(6'd0, 8'd0, 32'd0, 32'd0, 2'd0, 4'd0);
        repeat (2) @(posedge clk);
        #1;
        chk("rst/out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst/addr",      32'(bus.addr),      32'd0);
        chk("rst/is_store",  32'(bus.is_store),  32'd0);
        chk("rst/last",      32'(bus.last),      32'd0);
        chk("rst/misalign",  32'(bus.misalign),  32'd0);
        chk("rst/in_ready",  32'(bus.in_ready),  32'd1);
        reset = 1'b0;
        @(posedge clk); #1;

        do_req(c_op_ls, c_sub_lw, 32'h100, 32'h3, 2'd2, 4'd0, 1'b1, 8'hFF, 0, "lw");
        chk("lw/addr_value", 32'(exp_mis(12'h10C)), 32'd0);
        do_req(c_op_ls, c_sub_sw, 32'h040, 32'h20, 2'd3, 4'd0, 1'b1, 8'hFF, 0, "sw");
        do_req(c_op_swi, 8'h00,   32'h010, 32'h8,  2'd0, 4'd0, 1'b1, 8'hFF, 0, "swi");
        do_req(c_op_ls, c_sub_lmw, 32'h200, 32'h0, 2'd0, 4'd4, 1'b1, 8'b0010_1101, 0, "lmw4");
        do_req(c_op_ls, c_sub_lmw, 32'hFFC, 32'h0, 2'd0, 4'd2, 1'b1, 8'hFF, 0, "lmw_wrap");
        do_req(c_op_ls, c_sub_lmw, 32'h400, 32'h0, 2'd0, 4'd15, 1'b1, 8'hFF, 0, "lmw_sat");
        do_req(c_op_ls, c_sub_lmw, 32'h500, 32'h0, 2'd0, 4'd0, 1'b1, 8'hFF, 0, "lmw_zero");
        do_req(6'b111111, 8'h00,  32'h123, 32'h4, 2'd1, 4'd0, 1'b1, 8'hFF, 0, "illegal");
        do_req(c_op_ls, c_sub_lw, 32'h001, 32'h0, 2'd0, 4'd0, 1'b1, 8'hFF, 0, "misalign");

        // Back-to-back single-beat loads with no bubble between beats.
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        drive(c_op_lwi, 8'h00, 32'h000, 32'h0, 2'd0, 4'd0);
        for (int i = 0; i < 4; i++) begin
            drive(c_op_lwi, 8'h00, 32'h30 * i, 32'(i + 1), 2'd0, 4'd0);
            model(c_op_lwi, 8'h00, 32'h30 * i, 32'(i + 1), 2'd0, 4'd0);
            e = exp_q[0];
            @(posedge clk); #1;
            chk("b2b/out_valid", 32'(bus.out_valid), 32'd1);
            chk("b2b/addr",      32'(bus.addr),      32'(e.addr));
            chk("b2b/in_ready",  32'(bus.in_ready),  32'd1);
        end
        bus.in_valid = 1'b0;
        @(posedge clk); #1;
        chk("b2b/drain", 32'(bus.out_valid), 32'd0);

        // Reset in the middle of an eight-beat burst.
        drive(c_op_ls, c_sub_lmw, 32'h300, 32'h0, 2'd0, 4'd8);
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        chk("mid/beat0", 32'(bus.addr), 32'h300);
        @(posedge clk); #1;
        chk("mid/beat1", 32'(bus.addr), 32'h304);
        chk("mid/in_ready_busy", 32'(bus.in_ready), 32'd0);
        @(posedge clk); #1;
        chk("mid/beat2", 32'(bus.addr), 32'h308);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk("mid/out_valid", 32'(bus.out_valid), 32'd0);
        chk("mid/in_ready",  32'(bus.in_ready),  32'd1);
        chk("mid/addr",      32'(bus.addr),      32'd0);
        @(posedge clk); #1;
        chk("mid/stays_idle", 32'(bus.out_valid), 32'd0);

        // Random traffic with random backpressure.
        for (int t = 0; t < 40; t++) begin
            sel = int'($urandom_range(0, 6));
            op  = c_op_ls;
            sub = c_sub_lw;
            case (sel)
                0: op = c_op_lwi;
                1: op = c_op_swi;
                2: sub = c_sub_lw;
                3: sub = c_sub_sw;
                4: sub = c_sub_lmw;
                5: sub = 8'(($urandom_range(0, 1) == 0) ? 8'hFF : 8'h23);
                default: op = 6'b111111;
            endcase
            do_req(op, sub, $urandom(), 32'($urandom_range(0, 4095)), 2'($urandom_range(0, 3)),
                   4'($urandom_range(0, 15)), 1'b0, 8'h00, 65, "rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire
